signature_stream_out: RTL and testbench
=======================================

SIGNATURE_STREAM_OUT -- requirements
Module: signature_stream_out

Interface
REQ-001 Parameter HDR_MAGIC, default 16'hC5A1, magic value in header word bits [31:16].
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sig_in  input  520  signature from chip core (signature_out).
REQ-005 tx_in  input  256  formatted TX data from chip core (tx_data_out).
REQ-006 in_valid  input  1  result present (driven by core output_ready).
REQ-007 in_error  input  1  core output_error, sampled with in_valid.
REQ-008 in_ready  output  1  block can capture; high only in IDLE.
REQ-009 m_tdata  output  32  stream data word.
REQ-010 m_tvalid  output  1  stream word valid.
REQ-011 m_tready  input  1  downstream accepts word.
REQ-012 m_tlast  output  1  final word of packet.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 drop_count  output  8  count of in_valid cycles seen while not in IDLE; saturates at 8'hFF.

Function
REQ-015 Capture occurs when in_valid && in_ready: sig_in, tx_in and in_error latch into internal registers; inputs are ignored afterward.
REQ-016 FSM states IDLE, HDR, SIG, TX: IDLE->HDR on capture; HDR->SIG on handshake if no error; HDR->IDLE on handshake if error; SIG->TX after the 17th SIG handshake; TX->IDLE after the 8th TX handshake.
REQ-017 Handshake = m_tvalid && m_tready; the word counter advances only on a handshake.
REQ-018 m_tvalid is asserted the cycle after capture and stays high through HDR, SIG and TX.
REQ-019 While m_tvalid && !m_tready, m_tdata and m_tlast are held stable.
REQ-020 Header word = {HDR_MAGIC, in_error, 7'b0, seq[7:0]}.
REQ-021 SIG words are sent MS first: word 0 = {24'h0, sig[519:512]}, then sig[511:480], and so on down to sig[31:0]; 17 words total.
REQ-022 TX words are sent MS first: tx[255:224] down to tx[31:0]; 8 words.
REQ-023 m_tlast is high on TX word 7 and on the header of an error packet; it is low otherwise.
REQ-024 Normal packet = 26 words; error packet = 1 word.
REQ-025 seq increments by 1 on the m_tlast handshake and wraps 8'hFF->8'h00.
REQ-026 in_ready returns high in the cycle after the last handshake, so back-to-back packets lose at most one idle cycle.
REQ-027 in_valid while busy (including the cycle of the last handshake) is dropped and increments drop_count; it is never queued.
REQ-028 Minimum packet latency = 26 cycles from first m_tvalid when m_tready is held high.

Reset
REQ-029 Assertion of rst_n=0 at any time, including mid-packet, immediately forces: state IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, in_ready=0 while asserted, seq=0, drop_count=0, and capture registers to 0.
REQ-030 in_ready rises on the first clock edge after rst_n deasserts; the partial packet is discarded and never resumed.

Structure
REQ-031 Package virtual_chip_pkg holds the state enum, HDR_MAGIC default, SIG_WORDS=17, TX_WORDS=8 and the header field positions.
REQ-032 Single module, no sub-module: one 5-bit word counter with index muxes selecting from the capture registers; no shift register copies.

Verification
REQ-033 sig=520'h1..(0x01 in bits 519:512, byte-incrementing), tx=256'hA5.., in_error=0, m_tready=1 -> 26 words, header 32'hC5A1_0000, word1 32'h0000_0001, last on word 26, seq->1.
REQ-034 Same packet with m_tready toggling 1-0-0-1 pseudo-randomly -> data stable across stalls, identical word sequence, count 26.
REQ-035 in_error=1 -> single word 32'hC5A1_8000 with m_tlast=1, in_ready high next cycle.
REQ-036 in_valid pulsed 3 times mid-packet -> drop_count=3, only one packet emitted; 300 drops -> drop_count=8'hFF.
REQ-037 rst_n low at SIG word 5 -> m_tvalid=0 same cycle, seq=0; next capture restarts with header seq=0.
REQ-038 256 consecutive packets -> header seq runs 00..FF then 00; in_ready high the cycle after each m_tlast handshake.

Source files
------------

// File: rtl/virtual_chip_pkg.sv
// Shared types and constants for the signature output streamer: FSM states,
// packet geometry and header field layout.
package virtual_chip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SIG  = 2'd2,
    ST_TX   = 2'd3
  } state_t;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hC5A1;

  localparam int WORD_BITS = 32;
  localparam int SIG_BITS  = 520;
  localparam int TX_BITS   = 256;
  localparam int SIG_WORDS = 17;
  localparam int TX_WORDS  = 8;

  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_ERR_BIT   = 15;
  localparam int HDR_SEQ_LSB   = 0;

  function automatic logic [WORD_BITS-1:0] make_header(
    input logic [15:0] magic,
    input logic        err,
    input logic [7:0]  seq
  );
    logic [WORD_BITS-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_ERR_BIT]         = err;
    h[HDR_SEQ_LSB +: 8]    = seq;
    return h;
  endfunction

endpackage

// File: rtl/signature_stream_out.sv
// Serialises one captured signature/TX result into a 32-bit valid/ready stream:
// header, 17 signature words, 8 TX words (header only when the core flagged an error).
module signature_stream_out
  import virtual_chip_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIG_BITS-1:0]  sig_in,
  input  logic [TX_BITS-1:0]   tx_in,
  input  logic                 in_valid,
  input  logic                 in_error,
  output logic                 in_ready,
  output logic [WORD_BITS-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy,
  output logic [7:0]           drop_count
);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [SIG_BITS-1:0] sig_q;
  logic [TX_BITS-1:0]  tx_q;
  logic                err_q;
  logic [7:0]          seq_q;
  logic [7:0]          drop_q;
  logic                ready_en_q;

  logic                capture;
  logic                handshake;
  logic [4:0]          sig_idx;
  logic [2:0]          tx_idx;

  // Held low through reset so in_ready only rises on the first edge after release.
  assign in_ready   = ready_en_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign m_tvalid   = busy;
  assign drop_count = drop_q;

  assign capture   = in_valid && in_ready;
  assign handshake = m_tvalid && m_tready;

  // Word index counts from the most significant word down.
  assign sig_idx = 5'(SIG_WORDS - 1) - cnt_q;
  assign tx_idx  = 3'(TX_WORDS - 1) - cnt_q[2:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          state_d = err_q ? ST_IDLE : ST_SIG;
          cnt_d   = '0;
        end
      end
      ST_SIG: begin
        if (handshake) begin
          if (cnt_q == 5'(SIG_WORDS - 1)) begin
            state_d = ST_TX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_TX: begin
        if (handshake) begin
          if (cnt_q == 5'(TX_WORDS - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data and last are pure functions of registered state, so they hold during stalls.
  always_comb begin
    m_tdata = '0;
    m_tlast = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        m_tdata = make_header(HDR_MAGIC, err_q, seq_q);
        m_tlast = err_q;
      end
      ST_SIG: begin
        if (cnt_q == 5'd0) begin
          m_tdata = {24'h0, sig_q[SIG_BITS-1 -: 8]};
        end else begin
          m_tdata = sig_q[{sig_idx, 5'b0} +: WORD_BITS];
        end
      end
      ST_TX: begin
        m_tdata = tx_q[{tx_idx, 5'b0} +: WORD_BITS];
        m_tlast = (cnt_q == 5'(TX_WORDS - 1));
      end
      default: begin
        m_tdata = '0;
        m_tlast = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      if (handshake && m_tlast) begin
        seq_q <= seq_q + 8'd1;
      end
      if (in_valid && busy && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // NOTE: the wide capture registers are reset too, so a discarded packet leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
      tx_q  <= '0;
      err_q <= 1'b0;
    end else if (capture) begin
      sig_q <= sig_in;
      tx_q  <= tx_in;
      err_q <= in_error;
    end
  end

endmodule

// File: tb/tb_signature_stream_out.sv
// Self-checking bench for signature_stream_out: directed and random packets
// compared against a word-list model built from shifts of the captured vectors.
module tb_signature_stream_out;

  logic         clk;
  logic         rst_n;
  logic [519:0] sig_in;
  logic [255:0] tx_in;
  logic         in_valid;
  logic         in_error;
  logic         in_ready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         busy;
  logic [7:0]   drop_count;

  int n_checks;
  int n_errors;
  int exp_seq;
  int exp_drop;

  signature_stream_out dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .tx_in      (tx_in),
    .in_valid   (in_valid),
    .in_error   (in_error),
    .in_ready   (in_ready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [519:0] rand_sig();
    logic [519:0] v;
    v = '0;
    for (int i = 0; i < 17; i++) v = (v << 32) | 520'($urandom);
    return v;
  endfunction

  function automatic logic [255:0] rand_tx();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 32) | 256'($urandom);
    return v;
  endfunction

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  // Entered and left on a falling edge with the DUT idle and in_ready high.
  // abort_at >= 0 pulls reset while that word index is on the bus.
  task automatic run_packet(input logic [519:0] s, input logic [255:0] t, input logic e,
                            input bit stall, input bit drop3, input int flood, input int abort_at);
    logic [31:0]  exp_q[$];
    logic [519:0] sh;
    logic [255:0] th;
    logic [31:0]  held;
    bit           was_stall;
    int           idx;
    int           cyc;
    int           size;

    exp_q.push_back({16'hC5A1, e, 7'b0, exp_seq[7:0]});
    if (!e) begin
      sh = s >> 512;
      exp_q.push_back(sh[31:0]);
      for (int k = 1; k < 17; k++) begin
        sh = s >> (32 * (16 - k));
        exp_q.push_back(sh[31:0]);
      end
      for (int k = 0; k < 8; k++) begin
        th = t >> (32 * (7 - k));
        exp_q.push_back(th[31:0]);
      end
    end
    size = exp_q.size();

    check("ready_before_capture", in_ready, 1);
    sig_in   = s;
    tx_in    = t;
    in_error = e;
    in_valid = 1'b1;
    m_tready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    sig_in   = rand_sig();
    tx_in    = rand_tx();
    in_error = ~e;
    check("busy_after_capture", busy, 1);
    check("ready_low_busy", in_ready, 0);

    for (int f = 0; f < flood; f++) begin
      in_valid = 1'b1;
      bump_drop();
      @(negedge clk);
      check("hold_under_flood", m_tdata, exp_q[0]);
    end
    in_valid = 1'b0;
    if (flood > 0) check("drop_after_flood", drop_count, exp_drop);

    idx = 0;
    cyc = 0;
    was_stall = 0;
    held = '0;
    while (idx < size && cyc < 1000) begin
      if (idx == abort_at) begin
        check("word_before_reset", m_tdata, exp_q[idx]);
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_drop", drop_count, 0);
        exp_seq  = 0;
        exp_drop = 0;
        m_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_low_at_release", in_ready, 0);
        @(negedge clk);
        check("ready_after_release", in_ready, 1);
        check("tvalid_after_release", m_tvalid, 0);
        return;
      end
      check("tvalid", m_tvalid, 1);
      check("tdata", m_tdata, exp_q[idx]);
      check("tlast", m_tlast, (idx == size - 1));
      if (was_stall) check("stall_stable", m_tdata, held);
      held     = m_tdata;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = drop3 && m_tready && (idx == 3 || idx == 10 || idx == size - 1);
      if (in_valid) bump_drop();
      was_stall = !m_tready;
      if (m_tready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    m_tready = 1'b0;
    check("word_count", idx, size);
    check("tvalid_after_last", m_tvalid, 0);
    check("ready_after_last", in_ready, 1);
    check("drop_count", drop_count, exp_drop);
    exp_seq = (exp_seq + 1) % 256;
  endtask

  initial begin
    logic [519:0] dsig;
    logic [255:0] dtx;

    n_checks = 0;
    n_errors = 0;
    exp_seq  = 0;
    exp_drop = 0;
    rst_n    = 1'b0;
    sig_in   = '0;
    tx_in    = '0;
    in_valid = 1'b0;
    in_error = 1'b0;
    m_tready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tvalid", m_tvalid, 0);
    check("reset_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop_count, 0);
    check("reset_tdata", m_tdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    dsig = '0;
    for (int j = 0; j < 65; j++) dsig[519 - 8 * j -: 8] = 8'(j + 1);
    dtx = {32{8'hA5}};

    // Directed byte-incrementing packet, then the same with random stalls.
    run_packet(dsig, dtx, 1'b0, 1'b0, 1'b0, 0, -1);
    run_packet(dsig, dtx, 1'b0, 1'b1, 1'b0, 0, -1);

    // Error packet: header only, with the error bit.
    run_packet(rand_sig(), rand_tx(), 1'b1, 1'b0, 1'b0, 0, -1);

    // Three mid-packet in_valid pulses, one on the last handshake; then saturation.
    run_packet(rand_sig(), rand_tx(), 1'b0, 1'b0, 1'b1, 0, -1);
    run_packet(rand_sig(), rand_tx(), 1'b0, 1'b1, 1'b0, 300, -1);

    for (int p = 0; p < 4; p++) begin
      run_packet(rand_sig(), rand_tx(), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 0, -1);
    end

    // Reset while SIG word 5 is presented, then 257 back-to-back packets from seq 0.
    run_packet(rand_sig(), rand_tx(), 1'b0, 1'b0, 1'b0, 0, 6);
    for (int p = 0; p < 257; p++) begin
      run_packet(rand_sig(), rand_tx(), 1'b0, 1'b0, 1'b0, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
